// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one 64-bit memory bus between instruction fetch and the memory
// stage's data port. One request is latched at a time, the bus is driven
// until acknowledge or timeout, and the owner receives a registered
// one-cycle ready pulse together with read data.
//
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   -> when both requesters are eligible, the one not granted last wins
//   undefined -> fixed priority, data always beats fetch
module mem_bus_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024  // 0 disables timeout
) (
  input  logic        clk,
  input  logic        rst_n,
  // fetch port
  input  logic        instr_read_in,
  input  logic [63:0] instr_address_in,
  output logic        instr_ready_out,
  output logic [63:0] instr_read_value_out,
  // memory-stage port
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic [63:0] data_address_in,
  input  logic [7:0]  data_write_mask_in,
  input  logic [63:0] data_write_value_in,
  output logic        data_ready_out,
  output logic [63:0] data_read_value_out,
  // external bus
  output logic        bus_cyc_out,
  output logic        bus_we_out,
  output logic [7:0]  bus_sel_out,
  output logic [63:0] bus_address_out,
  output logic [63:0] bus_write_value_out,
  input  logic [63:0] bus_read_value_in,
  input  logic        bus_ack_in,
  output logic        error_out
);

  typedef enum logic [1:0] {
    IDLE,
    INSTR,
    DATA
  } state_t;

  state_t      state;
  logic [15:0] timeout_count;

  logic instr_eligible;
  logic data_eligible;
  logic grant_data;
  logic timeout_hit;

  // A request coincident with its own ready pulse has already been served.
  assign instr_eligible = instr_read_in && !instr_ready_out;
  assign data_eligible  = (data_read_in || data_write_in) && !data_ready_out;

  assign timeout_hit = (TIMEOUT_CYCLES != 16'd0) &&
                       (timeout_count == (TIMEOUT_CYCLES - 16'd1));

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant_data;

  // Data wins a tie only when fetch was the previous grantee.
  assign grant_data = data_eligible && (!instr_eligible || !last_grant_data);

  // Round-robin pointer: remembers who received the most recent grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_data <= 1'b1;
    end else if (state == IDLE && (instr_eligible || data_eligible)) begin
      last_grant_data <= grant_data;
    end
  end
`else
  // Fixed priority: data always beats fetch.
  assign grant_data = data_eligible;
`endif

  // Arbitration FSM with all bus and completion outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      timeout_count        <= 16'd0;
      instr_ready_out      <= 1'b0;
      instr_read_value_out <= 64'd0;
      data_ready_out       <= 1'b0;
      data_read_value_out  <= 64'd0;
      bus_cyc_out          <= 1'b0;
      bus_we_out           <= 1'b0;
      bus_sel_out          <= 8'd0;
      bus_address_out      <= 64'd0;
      bus_write_value_out  <= 64'd0;
      error_out            <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let these defaults be overridden
      // later in the block while every register still samples pre-edge values.
      instr_ready_out <= 1'b0;
      data_ready_out  <= 1'b0;
      error_out       <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_data) begin
            bus_cyc_out         <= 1'b1;
            bus_we_out          <= data_write_in;
            bus_sel_out         <= data_write_in ? data_write_mask_in : 8'hFF;
            bus_address_out     <= data_address_in;
            bus_write_value_out <= data_write_value_in;
            timeout_count       <= 16'd0;
            state               <= DATA;
          end else if (instr_eligible) begin
            bus_cyc_out         <= 1'b1;
            bus_we_out          <= 1'b0;
            bus_sel_out         <= 8'hFF;
            bus_address_out     <= instr_address_in;
            bus_write_value_out <= 64'd0;
            timeout_count       <= 16'd0;
            state               <= INSTR;
          end
        end

        INSTR, DATA: begin
          if (bus_ack_in) begin
            // Ack beats a coincident timeout.
            if (state == INSTR) begin
              instr_ready_out      <= 1'b1;
              instr_read_value_out <= bus_read_value_in;
            end else begin
              data_ready_out <= 1'b1;
              if (!bus_we_out) begin
                data_read_value_out <= bus_read_value_in;
              end
            end
            bus_cyc_out <= 1'b0;
            bus_we_out  <= 1'b0;
            state       <= IDLE;
          end else if (timeout_hit) begin
            if (state == INSTR) begin
              instr_ready_out      <= 1'b1;
              instr_read_value_out <= 64'd0;
            end else begin
              data_ready_out      <= 1'b1;
              data_read_value_out <= 64'd0;
            end
            error_out   <= 1'b1;
            bus_cyc_out <= 1'b0;
            bus_we_out  <= 1'b0;
            state       <= IDLE;
          end else begin
            timeout_count <= timeout_count + 16'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter (TIMEOUT_CYCLES = 4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic        instr_read_in;
  logic [63:0] instr_address_in;
  logic        instr_ready_out;
  logic [63:0] instr_read_value_out;
  logic        data_read_in;
  logic        data_write_in;
  logic [63:0] data_address_in;
  logic [7:0]  data_write_mask_in;
  logic [63:0] data_write_value_in;
  logic        data_ready_out;
  logic [63:0] data_read_value_out;
  logic        bus_cyc_out;
  logic        bus_we_out;
  logic [7:0]  bus_sel_out;
  logic [63:0] bus_address_out;
  logic [63:0] bus_write_value_out;
  logic [63:0] bus_read_value_in;
  logic        bus_ack_in;
  logic        error_out;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(16'd4)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .instr_read_in       (instr_read_in),
    .instr_address_in    (instr_address_in),
    .instr_ready_out     (instr_ready_out),
    .instr_read_value_out(instr_read_value_out),
    .data_read_in        (data_read_in),
    .data_write_in       (data_write_in),
    .data_address_in     (data_address_in),
    .data_write_mask_in  (data_write_mask_in),
    .data_write_value_in (data_write_value_in),
    .data_ready_out      (data_ready_out),
    .data_read_value_out (data_read_value_out),
    .bus_cyc_out         (bus_cyc_out),
    .bus_we_out          (bus_we_out),
    .bus_sel_out         (bus_sel_out),
    .bus_address_out     (bus_address_out),
    .bus_write_value_out (bus_write_value_out),
    .bus_read_value_in   (bus_read_value_in),
    .bus_ack_in          (bus_ack_in),
    .error_out           (error_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n              = 1'b0;
    instr_read_in      = 1'b0;
    instr_address_in   = 64'd0;
    data_read_in       = 1'b0;
    data_write_in      = 1'b0;
    data_address_in    = 64'd0;
    data_write_mask_in = 8'd0;
    data_write_value_in = 64'd0;
    bus_read_value_in  = 64'd0;
    bus_ack_in         = 1'b0;

    step();
    step();
    // reset state
    check("rst cyc", {63'd0, bus_cyc_out}, 64'd0);
    check("rst we", {63'd0, bus_we_out}, 64'd0);
    check("rst sel", {56'd0, bus_sel_out}, 64'd0);
    check("rst addr", bus_address_out, 64'd0);
    check("rst irdy", {63'd0, instr_ready_out}, 64'd0);
    check("rst drdy", {63'd0, data_ready_out}, 64'd0);
    check("rst err", {63'd0, error_out}, 64'd0);
    check("rst dval", data_read_value_out, 64'd0);
    rst_n = 1'b1;
    step();

    // ack while idle is ignored
    bus_ack_in = 1'b1;
    step();
    bus_ack_in = 1'b0;
    check("idle ack cyc", {63'd0, bus_cyc_out}, 64'd0);
    check("idle ack irdy", {63'd0, instr_ready_out}, 64'd0);
    check("idle ack drdy", {63'd0, data_ready_out}, 64'd0);

    // ---- fetch only, ack 3 cycles after cyc ----
    instr_read_in    = 1'b1;
    instr_address_in = 64'h1000;
    step();                                   // grant edge N
    check("f cyc", {63'd0, bus_cyc_out}, 64'd1);
    check("f we", {63'd0, bus_we_out}, 64'd0);
    check("f sel", {56'd0, bus_sel_out}, 64'hFF);
    check("f addr", bus_address_out, 64'h1000);
    step();                                   // N+1
    check("f hold rdy", {63'd0, instr_ready_out}, 64'd0);
    step();                                   // N+2
    bus_ack_in        = 1'b1;
    bus_read_value_in = 64'hDEADBEEF_00000013;
    step();                                   // N+3 samples ack
    bus_ack_in        = 1'b0;
    instr_read_in     = 1'b0;
    check("f irdy", {63'd0, instr_ready_out}, 64'd1);
    check("f ival", instr_read_value_out, 64'hDEADBEEF_00000013);
    check("f err", {63'd0, error_out}, 64'd0);
    check("f drdy", {63'd0, data_ready_out}, 64'd0);
    check("f cyc drop", {63'd0, bus_cyc_out}, 64'd0);
    step();
    check("f irdy pulse", {63'd0, instr_ready_out}, 64'd0);

    // ---- data write ----
    data_write_in       = 1'b1;
    data_address_in     = 64'h2008;
    data_write_mask_in  = 8'b0000_1111;
    data_write_value_in = 64'h11223344;
    step();
    check("w cyc", {63'd0, bus_cyc_out}, 64'd1);
    check("w we", {63'd0, bus_we_out}, 64'd1);
    check("w sel", {56'd0, bus_sel_out}, 64'h0F);
    check("w addr", bus_address_out, 64'h2008);
    check("w wdata", bus_write_value_out, 64'h11223344);
    bus_ack_in        = 1'b1;
    bus_read_value_in = 64'hBAD0BAD0;
    step();
    bus_ack_in    = 1'b0;
    data_write_in = 1'b0;
    check("w drdy", {63'd0, data_ready_out}, 64'd1);
    check("w irdy", {63'd0, instr_ready_out}, 64'd0);
    check("w dval kept", data_read_value_out, 64'd0);
    check("w we drop", {63'd0, bus_we_out}, 64'd0);
    step();
    check("w drdy pulse", {63'd0, data_ready_out}, 64'd0);

    // ---- simultaneous fetch and data load ----
    instr_read_in    = 1'b1;
    instr_address_in = 64'h1008;
    data_read_in     = 1'b1;
    data_address_in  = 64'h3000;
    step();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    check("b1 addr", bus_address_out, 64'h1008);
    bus_ack_in = 1'b1; bus_read_value_in = 64'hB;
    step();
    bus_ack_in = 1'b0; instr_read_in = 1'b0;
    check("b1 irdy", {63'd0, instr_ready_out}, 64'd1);
    check("b1 drdy", {63'd0, data_ready_out}, 64'd0);
    check("b1 ival", instr_read_value_out, 64'hB);
    step();
    check("b2 addr", bus_address_out, 64'h3000);
    check("b2 cyc", {63'd0, bus_cyc_out}, 64'd1);
    bus_ack_in = 1'b1; bus_read_value_in = 64'hA;
    step();
    bus_ack_in = 1'b0; data_read_in = 1'b0;
    check("b2 drdy", {63'd0, data_ready_out}, 64'd1);
    check("b2 dval", data_read_value_out, 64'hA);
`else
    check("b1 addr", bus_address_out, 64'h3000);
    check("b1 we", {63'd0, bus_we_out}, 64'd0);
    bus_ack_in = 1'b1; bus_read_value_in = 64'hA;
    step();
    bus_ack_in = 1'b0; data_read_in = 1'b0;
    check("b1 drdy", {63'd0, data_ready_out}, 64'd1);
    check("b1 irdy", {63'd0, instr_ready_out}, 64'd0);
    check("b1 dval", data_read_value_out, 64'hA);
    step();
    check("b2 addr", bus_address_out, 64'h1008);
    check("b2 cyc", {63'd0, bus_cyc_out}, 64'd1);
    bus_ack_in = 1'b1; bus_read_value_in = 64'hB;
    step();                                   // two cycles after data ready
    bus_ack_in = 1'b0; instr_read_in = 1'b0;
    check("b2 irdy", {63'd0, instr_ready_out}, 64'd1);
    check("b2 ival", instr_read_value_out, 64'hB);
`endif
    step();

    // ---- timeout, ack never asserted ----
    data_read_in    = 1'b1;
    data_address_in = 64'h4000;
    step();                                   // grant
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("t cyc %0d", i), {63'd0, bus_cyc_out}, 64'd1);
      check($sformatf("t drdy %0d", i), {63'd0, data_ready_out}, 64'd0);
    end
    step();                                   // 4th owned cycle ends
    data_read_in = 1'b0;
    check("t cyc drop", {63'd0, bus_cyc_out}, 64'd0);
    check("t drdy", {63'd0, data_ready_out}, 64'd1);
    check("t err", {63'd0, error_out}, 64'd1);
    check("t dval", data_read_value_out, 64'd0);
    step();
    check("t err pulse", {63'd0, error_out}, 64'd0);

    // ---- ack on the 4th owned cycle ----
    data_read_in    = 1'b1;
    data_address_in = 64'h5000;
    step();
    step();
    step();
    step();
    bus_ack_in = 1'b1; bus_read_value_in = 64'hC0FFEE;
    step();
    bus_ack_in = 1'b0; data_read_in = 1'b0;
    check("a4 drdy", {63'd0, data_ready_out}, 64'd1);
    check("a4 err", {63'd0, error_out}, 64'd0);
    check("a4 dval", data_read_value_out, 64'hC0FFEE);
    step();

    // ---- reset mid-transaction ----
    data_write_in       = 1'b1;
    data_address_in     = 64'h6000;
    data_write_mask_in  = 8'hF0;
    data_write_value_in = 64'h55;
    step();
    check("r cyc", {63'd0, bus_cyc_out}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("r cyc async", {63'd0, bus_cyc_out}, 64'd0);
    check("r drdy", {63'd0, data_ready_out}, 64'd0);
    step();
    rst_n = 1'b1;
    check("r drdy held", {63'd0, data_ready_out}, 64'd0);
    step();
    check("r regrant cyc", {63'd0, bus_cyc_out}, 64'd1);
    check("r regrant addr", bus_address_out, 64'h6000);
    check("r regrant sel", {56'd0, bus_sel_out}, 64'hF0);
    bus_ack_in = 1'b1;
    step();
    bus_ack_in = 1'b0; data_write_in = 1'b0;
    check("r drdy done", {63'd0, data_ready_out}, 64'd1);
    check("r err", {63'd0, error_out}, 64'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
